// File: rtl/fifo_sample_reader_pkg.sv
// Shared types and default widths for the FIFO sample reader.
package fifo_sample_reader_pkg;

    localparam int DWIDTH_DEF = 32;
    localparam int DIVW_DEF   = 8;
    localparam int CNTW_DEF   = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        RUN    = 2'd2,
        STARVE = 2'd3
    } state_t;

endpackage

// File: rtl/fifo_sample_reader_tick_gen.sv
// Programmable sample-rate divider: tick every rate_div+1 cycles while cnt_en is high.
module sample_tick_gen #(
    parameter int DIVW = 8
) (
    input  logic            rclk,
    input  logic            rst,
    input  logic            load_zero,
    input  logic            cnt_en,
    input  logic [DIVW-1:0] rate_div,
    output logic            tick
);

    localparam logic [DIVW-1:0] DIV_ONE = DIVW'(1);

    logic [DIVW-1:0] cnt_r;

    // Count down to zero, reloading from rate_div so a new rate applies at the next reload
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (load_zero) begin
            cnt_r <= '0;
        end else if (cnt_en) begin
            if (cnt_r == '0) begin
                cnt_r <= rate_div;
            end else begin
                cnt_r <= cnt_r - DIV_ONE;
            end
        end
    end

    assign tick = cnt_en && (cnt_r == '0);

endmodule

// File: rtl/fifo_sample_reader.sv
// DAC-domain consumer of a first-word-fall-through sample FIFO with priming and underrun handling.
// Optional build macro FIFO_READER_UNDERRUN_MUTE_EN: zero dout on starved ticks instead of holding.
module fifo_sample_reader
    import fifo_sample_reader_pkg::*;
#(
    parameter int DWIDTH       = DWIDTH_DEF,
    parameter int DIVW         = DIVW_DEF,
    parameter int PRIME_CYCLES = 16,
    parameter int CNTW         = CNTW_DEF
) (
    input  logic              rclk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DIVW-1:0]   rate_div,
    input  logic [DWIDTH-1:0] fifo_rdata,
    input  logic              fifo_empty,
    output logic              fifo_read_en,
    output logic [DWIDTH-1:0] dout,
    output logic              dout_valid,
    output logic              underrun,
    output logic [CNTW-1:0]   underrun_cnt,
    output logic              running
);

    localparam int PW = $clog2(PRIME_CYCLES + 1) + 1;
    localparam logic [PW-1:0]   PRIME_LAST = PW'(PRIME_CYCLES - 1);
    localparam logic [PW-1:0]   PRIME_ONE  = PW'(1);
    localparam logic [CNTW-1:0] CNT_ONE    = CNTW'(1);

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        sat_inc = (v == {CNTW{1'b1}}) ? v : v + CNT_ONE;
    endfunction

    state_t            state_r;
    logic [PW-1:0]     prime_cnt_r;
    logic [DWIDTH-1:0] dout_r;
    logic              dout_valid_r;
    logic              underrun_r;
    logic [CNTW-1:0]   underrun_cnt_r;
    logic              running_r;
    logic              tick_s;
    logic              cnt_en_s;
    logic              load_zero_s;

    assign cnt_en_s    = (state_r == RUN) || (state_r == STARVE);
    assign load_zero_s = (state_r == PRIME) && enable && !fifo_empty && (prime_cnt_r == PRIME_LAST);

    sample_tick_gen #(.DIVW(DIVW)) u_tick (
        .rclk      (rclk),
        .rst       (rst),
        .load_zero (load_zero_s),
        .cnt_en    (cnt_en_s),
        .rate_div  (rate_div),
        .tick      (tick_s)
    );

    // A pop is only ever a tick with data present and the run request still held
    assign fifo_read_en = tick_s && !fifo_empty && enable;

    // Reader state machine with registered sample, strobes and underrun count
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            state_r        <= IDLE;
            prime_cnt_r    <= '0;
            dout_r         <= '0;
            dout_valid_r   <= 1'b0;
            underrun_r     <= 1'b0;
            underrun_cnt_r <= '0;
            running_r      <= 1'b0;
        end else begin
            dout_valid_r <= 1'b0;
            underrun_r   <= 1'b0;
            if (!enable) begin
                state_r     <= IDLE;
                prime_cnt_r <= '0;
                dout_r      <= '0;
                running_r   <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r     <= PRIME;
                        prime_cnt_r <= '0;
                    end
                    PRIME: begin
                        if (fifo_empty) begin
                            prime_cnt_r <= '0;
                        end else if (prime_cnt_r == PRIME_LAST) begin
                            state_r     <= RUN;
                            running_r   <= 1'b1;
                            prime_cnt_r <= '0;
                        end else begin
                            prime_cnt_r <= prime_cnt_r + PRIME_ONE;
                        end
                    end
                    RUN, STARVE: begin
                        if (tick_s) begin
                            if (!fifo_empty) begin
                                dout_r       <= fifo_rdata;
                                dout_valid_r <= 1'b1;
                                state_r      <= RUN;
                            end else begin
                                underrun_r     <= 1'b1;
                                underrun_cnt_r <= sat_inc(underrun_cnt_r);
                                state_r        <= STARVE;
`ifdef FIFO_READER_UNDERRUN_MUTE_EN
                                dout_r         <= '0;
`else
                                dout_r         <= dout_r;
`endif
                            end
                        end
                    end
                    default: begin
                        state_r   <= IDLE;
                        running_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign dout         = dout_r;
    assign dout_valid   = dout_valid_r;
    assign underrun     = underrun_r;
    assign underrun_cnt = underrun_cnt_r;
    assign running      = running_r;

endmodule

// File: tb/tb_fifo_sample_reader.sv
// Self-checking bench for fifo_sample_reader: FIFO model, pop scoreboard, table-driven timing vectors.
module tb_fifo_sample_reader;

    logic        rclk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  rate_div = 8'd0;
    logic [31:0] fifo_rdata = 32'd0;
    logic        fifo_empty = 1'b1;
    logic        fifo_read_en;
    logic [31:0] dout;
    logic        dout_valid;
    logic        underrun;
    logic [15:0] underrun_cnt;
    logic        running;

    logic        enable2 = 1'b0;
    logic        fifo_empty2 = 1'b1;
    logic [7:0]  fifo_rdata2 = 8'h5A;
    logic        fifo_read_en2;
    logic [7:0]  dout2;
    logic        dout_valid2;
    logic        underrun2;
    logic [2:0]  underrun_cnt2;
    logic        running2;

    int total = 0;
    int bad = 0;
    logic [31:0] fq[$];
    logic [31:0] sb[$];

    always #5 rclk = ~rclk;

    fifo_sample_reader dut (
        .rclk(rclk), .rst(rst), .enable(enable), .rate_div(rate_div),
        .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty), .fifo_read_en(fifo_read_en),
        .dout(dout), .dout_valid(dout_valid), .underrun(underrun),
        .underrun_cnt(underrun_cnt), .running(running)
    );

    fifo_sample_reader #(.DWIDTH(8), .DIVW(8), .PRIME_CYCLES(2), .CNTW(3)) dut_sat (
        .rclk(rclk), .rst(rst), .enable(enable2), .rate_div(rate_div),
        .fifo_rdata(fifo_rdata2), .fifo_empty(fifo_empty2), .fifo_read_en(fifo_read_en2),
        .dout(dout2), .dout_valid(dout_valid2), .underrun(underrun2),
        .underrun_cnt(underrun_cnt2), .running(running2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        enable2 = 1'b0;
        fifo_empty2 = 1'b1;
        fq.delete();
        sb.delete();
        @(negedge rclk);
        @(negedge rclk);
        rst = 1'b0;
    endtask

    // One clock of the FIFO model; popped words go to the scoreboard and are checked next cycle
    task automatic step(input bit force_empty, output bit pop);
        logic [31:0] exp_w;
        fifo_empty = force_empty || (fq.size() == 0);
        fifo_rdata = (fq.size() == 0) ? 32'd0 : fq[0];
        #1;
        pop = fifo_read_en;
        chk("pop_while_empty", {63'd0, pop & fifo_empty}, 64'd0);
        if (pop && !fifo_empty) begin
            sb.push_back(fq[0]);
            void'(fq.pop_front());
        end
        @(posedge rclk);
        @(negedge rclk);
        if (sb.size() != 0) begin
            exp_w = sb.pop_front();
            chk("dout_valid_after_pop", {63'd0, dout_valid}, 64'd1);
            chk("dout_word", {32'd0, dout}, {32'd0, exp_w});
        end else begin
            chk("dout_valid_idle", {63'd0, dout_valid}, 64'd0);
        end
    endtask

    typedef struct {
        logic [7:0]  rate;
        int          nwords;
        logic [31:0] base;
        int          glitch;
        int          exp_first;
    } vec_t;

    vec_t tbl[4];

    initial begin
        bit p;
        int first;
        int last;
        int npop;
        logic [31:0] hold_exp;

        tbl[0] = '{rate: 8'd3, nwords: 3, base: 32'h1,        glitch: 0,  exp_first: 18};
        tbl[1] = '{rate: 8'd0, nwords: 4, base: 32'h100,      glitch: 0,  exp_first: 18};
        tbl[2] = '{rate: 8'd7, nwords: 3, base: 32'hDEAD0000, glitch: 10, exp_first: 27};
        tbl[3] = '{rate: 8'd1, nwords: 5, base: 32'h55,       glitch: 17, exp_first: 34};

        do_reset();
        #1;
        chk("rst_dout", {32'd0, dout}, 64'd0);
        chk("rst_valid", {63'd0, dout_valid}, 64'd0);
        chk("rst_underrun", {63'd0, underrun}, 64'd0);
        chk("rst_cnt", {48'd0, underrun_cnt}, 64'd0);
        chk("rst_running", {63'd0, running}, 64'd0);
        chk("rst_read_en", {63'd0, fifo_read_en}, 64'd0);
        @(negedge rclk);

        // Priming latency, pop spacing and data order per vector
        for (int v = 0; v < 4; v++) begin
            do_reset();
            rate_div = tbl[v].rate;
            for (int i = 0; i < tbl[v].nwords; i++) fq.push_back(tbl[v].base + 32'(i));
            enable = 1'b1;
            first = -1;
            last = -1;
            npop = 0;
            for (int s = 1; s <= tbl[v].exp_first + (tbl[v].nwords - 1) * (int'(tbl[v].rate) + 1); s++) begin
                step(s == tbl[v].glitch, p);
                if (s == tbl[v].exp_first - 2) chk("running_before_run", {63'd0, running}, 64'd0);
                if (s == tbl[v].exp_first - 1) chk("running_in_run", {63'd0, running}, 64'd1);
                if (p) begin
                    if (first < 0) first = s;
                    else chk("pop_gap", 64'(s - last), 64'(int'(tbl[v].rate) + 1));
                    last = s;
                    npop++;
                end
            end
            chk("first_pop_cycle", 64'(first), 64'(tbl[v].exp_first));
            chk("pop_count", 64'(npop), 64'(tbl[v].nwords));
        end

        // Back-to-back pops then underrun
        do_reset();
        rate_div = 8'd0;
        for (int i = 1; i <= 8; i++) fq.push_back(32'(i * 'h11));
        enable = 1'b1;
        npop = 0;
        for (int s = 1; s <= 25; s++) begin
            step(1'b0, p);
            if (p) npop++;
            if (s == 17) chk("no_pop_in_prime", 64'(npop), 64'd0);
        end
        chk("burst_pops", 64'(npop), 64'd8);
        step(1'b0, p);
`ifdef FIFO_READER_UNDERRUN_MUTE_EN
        hold_exp = 32'h0;
`else
        hold_exp = 32'h88;
`endif
        chk("underrun_pulse", {63'd0, underrun}, 64'd1);
        chk("underrun_cnt_1", {48'd0, underrun_cnt}, 64'd1);
        chk("running_starve", {63'd0, running}, 64'd1);
        chk("dout_on_underrun", {32'd0, dout}, {32'd0, hold_exp});

        // Continued starvation, then recovery without re-prime
        for (int i = 0; i < 3; i++) begin
            step(1'b0, p);
            chk("starve_pulse", {63'd0, underrun}, 64'd1);
        end
        chk("underrun_cnt_4", {48'd0, underrun_cnt}, 64'd4);
        rate_div = 8'd3;
        fq.push_back(32'hA5);
        for (int i = 0; i < 4; i++) fq.push_back(32'hB0 + 32'(i));
        step(1'b0, p);
        chk("recover_pop", {63'd0, p}, 64'd1);
        chk("recover_no_underrun", {63'd0, underrun}, 64'd0);
        chk("recover_cnt", {48'd0, underrun_cnt}, 64'd4);

        // Drop enable exactly on a tick: no pop, dout cleared
        for (int i = 0; i < 3; i++) begin
            step(1'b0, p);
            chk("no_pop_between_ticks", {63'd0, p}, 64'd0);
        end
        enable = 1'b0;
        step(1'b0, p);
        chk("no_pop_on_disable", {63'd0, p}, 64'd0);
        chk("dout_cleared", {32'd0, dout}, 64'd0);
        chk("running_off", {63'd0, running}, 64'd0);
        chk("cnt_retained", {48'd0, underrun_cnt}, 64'd4);
        enable = 1'b1;
        npop = 0;
        for (int s = 1; s <= 18; s++) begin
            step(1'b0, p);
            if (p) npop++;
            if (s == 17) chk("reprime_no_pop", 64'(npop), 64'd0);
        end
        chk("reprime_first_pop", 64'(npop), 64'd1);
        chk("cnt_after_reprime", {48'd0, underrun_cnt}, 64'd4);

        // Saturation on a narrow counter
        rate_div = 8'd0;
        enable2 = 1'b1;
        fifo_empty2 = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, p);
        fifo_empty2 = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, p);
        chk("sat_cnt_3", {61'd0, underrun_cnt2}, 64'd3);
        for (int i = 0; i < 9; i++) step(1'b0, p);
        chk("sat_cnt_max", {61'd0, underrun_cnt2}, 64'd7);
        chk("sat_still_pulses", {63'd0, underrun2}, 64'd1);

        // Asynchronous reset between edges while a pop is pending
        fq.delete();
        fq.push_back(32'hC0);
        fifo_empty = 1'b0;
        fifo_rdata = 32'hC0;
        #1;
        chk("pre_reset_pop", {63'd0, fifo_read_en}, 64'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_read_en", {63'd0, fifo_read_en}, 64'd0);
        chk("arst_dout", {32'd0, dout}, 64'd0);
        chk("arst_valid", {63'd0, dout_valid}, 64'd0);
        chk("arst_cnt", {48'd0, underrun_cnt}, 64'd0);
        chk("arst_running", {63'd0, running}, 64'd0);
        chk("arst_cnt2", {61'd0, underrun_cnt2}, 64'd0);
        fq.delete();
        sb.delete();
        @(negedge rclk);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
